cia_share_arb: RTL and testbench
================================

# cia_share_arb

Round-robin arbiter and sequencer that shares one N-bit carry-increment adder (`CIA_01`) between two requesters. Each requester presents operands through a valid/ready handshake, and the block grants one requester at a time. It captures that requester's operands, runs them through the adder, and returns the registered sum and carry-out on that requester's response channel. The block sits between the datapath clients and the single adder instance it owns.

## Interface
- `N`, default 16: operand and sum width, passed to the `CIA_01` instance.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  requester has operands ready.
- `req0_ready` / `req1_ready`  out  1  operands accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  N  operands.
- `req0_cin` / `req1_cin`  in  1  carry-in.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the result.
- `rsp_sum`  out  N  registered sum, shared by both response channels.
- `rsp_cout`  out  1  registered carry-out.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE: grant selection
  - If exactly one `reqX_valid` is high, that requester is granted.
  - If both are high, the requester indicated by the round-robin pointer `rr` is granted.
  - `reqX_ready` is combinational: `(state==IDLE) && grant==X && reqX_valid`.
  - On handshake, a, b and cin are captured into internal registers, the granted id is latched, and the FSM goes to CALC.
- CALC: the adder sees only the captured operand registers. `rsp_sum`/`rsp_cout` load the adder outputs and the FSM goes to RESP.
- RESP
  - `rsp<id>_valid` is high; the other `rspY_valid` stays low.
  - `rsp_sum`/`rsp_cout` hold stable until `rsp<id>_ready`.
  - On `rsp<id>_ready`, go to IDLE and set `rr` to the requester not just served.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(N+1). No sign interpretation.
- A request on the non-granted channel is held off (`ready` low) and never dropped. The requester must keep valid and operands stable until ready.
- Operand changes after acceptance have no effect on the in-flight operation.

## Timing
- Reset values: all `reqX_ready`=0, `rspX_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `busy`=0, state=IDLE, `rr`=0 (req0 preferred first).
- Latency: handshake at edge T, result registered at T+1, `rsp_valid` high in the cycle after edge T+1.
- Minimum issue interval: 3 cycles per operation (IDLE, CALC, RESP), with zero-wait response.
- Response backpressure stalls the FSM in RESP indefinitely, and no new request is accepted meanwhile.
- Simultaneous valid on both channels at reset exit: req0 is served first, then req1 (`rr` flips).
- Back-to-back, both valid continuously: grants alternate 0,1,0,1.
- Reset asserted mid-operation: the in-flight operation is discarded, outputs go immediately to reset values, and no response is issued after reset release.
- `rspX_ready` asserted while its `rspX_valid` is low is ignored.

## Configuration
- `CIA_SAT_EN`
  - Defined: unsigned saturation. When the adder's cout=1, `rsp_sum` loads all-ones (2^N-1) and `rsp_cout` still reports 1.
  - Undefined: `rsp_sum` is the raw modulo sum.
  - Timing and handshake are identical in both builds.

## Test plan
- Single request, N=16: req0 a=0xADC0, b=0xFE80, cin=1 -> `rsp0_valid` two cycles after accept, sum=0xAC41, cout=1. With `CIA_SAT_EN`: sum=0xFFFF, cout=1.
- req1 alone, a=0x006C, b=0x0232, cin=1 -> `rsp1_valid`, sum=0x029F, cout=0. `rsp0_valid` stays 0 throughout.
- Both valid from reset, req0 a=0x3A9A, b=0xE544, cin=0 and req1 a=0x0001, b=0x0001, cin=0 -> req0 served first (sum=0x1FDE, cout=1), then req1 (sum=0x0002, cout=0). Continuous valid yields alternating grants 0,1,0,1.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles with req1 valid -> `rsp_sum` stable, `busy`=1, `req1_ready`=0 throughout. Release -> req1 accepted in the next IDLE cycle.
- Reset mid-CALC: assert `rst_n`=0 one cycle after accept -> all outputs zero asynchronously. After release, no `rsp_valid` appears without a new request, and `rr`=0.
- Operand change after accept: alter `req0_a` in CALC -> response reflects the captured operands only.

Source files
------------

// File: rtl/cia_share_arb.sv
// cia_share_arb: round-robin arbiter/sequencer sharing one carry-increment adder between two requesters.
// Build macro CIA_SAT_EN: when defined, rsp_sum saturates to all-ones on carry-out.

module CIA_01 #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int unsigned BW = 4;
  localparam int unsigned NB = (N + BW - 1) / BW;
  localparam int unsigned W  = NB * BW;

  logic [W-1:0] ap, bp, sp;
  logic [NB:0]  c;
  logic [W:0]   full;

  assign ap   = W'(a);
  assign bp   = W'(b);
  assign c[0] = cin;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BW:0] s0, s1;
    // each block precomputes sum and sum+1; the incoming carry only selects
    assign s0 = {1'b0, ap[g*BW +: BW]} + {1'b0, bp[g*BW +: BW]};
    assign s1 = s0 + (BW+1)'(1);
    assign sp[g*BW +: BW] = c[g] ? s1[BW-1:0] : s0[BW-1:0];
    assign c[g+1]         = c[g] ? s1[BW]     : s0[BW];
  end

  // carry out of bit N-1 sits in the padded sum when N is not a block multiple
  assign full = {c[NB], sp};
  assign sum  = full[N-1:0];
  assign cout = full[N];
endmodule

module cia_share_arb #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t       state;
  logic         rr;
  logic         id;
  logic         grant;
  logic [N-1:0] op_a, op_b;
  logic         op_cin;
  logic [N-1:0] add_sum, res_sum;
  logic         add_cout;

  // single valid wins outright; contention goes to the round-robin pointer
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = rr;
    else                          grant = req1_valid;
  end

  assign req0_ready = rst_n && (state == IDLE) && !grant && req0_valid;
  assign req1_ready = rst_n && (state == IDLE) &&  grant && req1_valid;
  assign rsp0_valid = (state == RESP) && !id;
  assign rsp1_valid = (state == RESP) &&  id;
  assign busy       = (state != IDLE);

  CIA_01 #(.N(N)) u_cia (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef CIA_SAT_EN
  assign res_sum = add_cout ? '1 : add_sum;
`else
  assign res_sum = add_sum;
`endif

  // sequencer: capture operands, register adder result, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      id       <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a   <= grant ? req1_a   : req0_a;
            op_b   <= grant ? req1_b   : req0_b;
            op_cin <= grant ? req1_cin : req0_cin;
            id     <= grant;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_sum  <= res_sum;
          rsp_cout <= add_cout;
          state    <= RESP;
        end
        RESP: begin
          if (id ? rsp1_ready : rsp0_ready) begin
            rr    <= ~id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cia_share_arb.sv
// Self-checking bench for cia_share_arb: transaction-level model checked every cycle, directed + random stimulus.
// Honours CIA_SAT_EN for expected sums.
`timescale 1ns/1ps
module tb_cia_share_arb;
  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [N-1:0] rsp_sum;
  logic         rsp_cout, busy;

  always #5 clk = ~clk;

  cia_share_arb #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

`ifdef CIA_SAT_EN
  localparam logic [15:0] T1_SUM = 16'hFFFF;
  localparam logic [15:0] T3_SUM = 16'hFFFF;
`else
  localparam logic [15:0] T1_SUM = 16'hAC41;
  localparam logic [15:0] T3_SUM = 16'h1FDE;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // transaction-level model: one op in flight, result visible two cycles after accept
  bit          m_rr, m_busy, m_id, m_acc0, m_acc1;
  int          m_age;
  logic [16:0] m_res;
  logic [15:0] m_shown_sum;
  logic        m_shown_cout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_busy = 0; m_id = 0; m_age = 0; m_res = '0;
    m_shown_sum = '0; m_shown_cout = 1'b0; m_acc0 = 0; m_acc1 = 0;
  endtask

  // called just after a negedge with inputs already applied; returns just after the next negedge
  task automatic step();
    bit g, e_r0, e_r1, e_v0, e_v1;
    #1;
    if (!rst_n) model_reset();
    g    = (req0_valid && req1_valid) ? m_rr : req1_valid;
    e_r0 = rst_n && !m_busy && req0_valid && !g;
    e_r1 = rst_n && !m_busy && req1_valid &&  g;
    e_v0 = m_busy && m_age >= 2 && !m_id;
    e_v1 = m_busy && m_age >= 2 &&  m_id;
    chk("req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("rsp_sum",    32'(rsp_sum),    32'(m_shown_sum));
    chk("rsp_cout",   32'(rsp_cout),   32'(m_shown_cout));
    m_acc0 = e_r0;
    m_acc1 = e_r1;
    @(posedge clk);
    if (rst_n) begin
      if (!m_busy) begin
        if (e_r0 || e_r1) begin
          m_busy = 1; m_id = e_r1; m_age = 1;
          m_res = e_r1 ? 17'(req1_a) + 17'(req1_b) + 17'(req1_cin)
                       : 17'(req0_a) + 17'(req0_b) + 17'(req0_cin);
        end
      end else if (m_age == 1) begin
`ifdef CIA_SAT_EN
        m_shown_sum = m_res[16] ? 16'hFFFF : m_res[15:0];
`else
        m_shown_sum = m_res[15:0];
`endif
        m_shown_cout = m_res[16];
        m_age = 2;
      end else if (m_id ? rsp1_ready : rsp0_ready) begin
        m_busy = 0;
        m_rr = !m_id;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drain();
    int k = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    while (m_busy && k < 20) begin step(); k++; end
    chk("drain_idle", 32'(busy), 32'(0));
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  int gq[$];
  bit hold0, hold1;

  initial begin
    model_reset();
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_a = '0; req1_b = '0; req1_cin = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    step(); step();
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_sum",  32'(rsp_sum), 32'(0));
    rst_n = 1;
    step();

    // single req0, operands changed while in flight
    req0_valid = 1; req0_a = 16'hADC0; req0_b = 16'hFE80; req0_cin = 1;
    #1 chk("t1_accept", 32'(req0_ready), 32'(1));
    step();
    req0_valid = 0; req0_a = 16'h1111; req0_b = 16'h0000; req0_cin = 0;
    #1 chk("t1_calc_valid", 32'(rsp0_valid), 32'(0));
    step();
    #1 chk("t1_rsp_valid", 32'(rsp0_valid), 32'(1));
    chk("t1_sum", 32'(rsp_sum), 32'(T1_SUM));
    chk("t1_cout", 32'(rsp_cout), 32'(1));
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;

    // single req1
    req1_valid = 1; req1_a = 16'h006C; req1_b = 16'h0232; req1_cin = 1;
    #1 chk("t2_accept", 32'(req1_ready), 32'(1));
    step();
    req1_valid = 0;
    step();
    #1 chk("t2_rsp_valid", 32'(rsp1_valid), 32'(1));
    chk("t2_rsp0_low", 32'(rsp0_valid), 32'(0));
    chk("t2_sum", 32'(rsp_sum), 32'(16'h029F));
    chk("t2_cout", 32'(rsp_cout), 32'(0));
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;

    // both valid straight out of reset
    rst_n = 0;
    req0_valid = 1; req0_a = 16'h3A9A; req0_b = 16'hE544; req0_cin = 0;
    req1_valid = 1; req1_a = 16'h0001; req1_b = 16'h0001; req1_cin = 0;
    step(); step();
    rst_n = 1;
    #1 chk("t3_first_req0", 32'({req0_ready, req1_ready}), 32'(2'b10));
    step();
    req0_valid = 0;
    step();
    #1 chk("t3_sum0", 32'(rsp_sum), 32'(T3_SUM));
    chk("t3_cout0", 32'(rsp_cout), 32'(1));
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    #1 chk("t3_then_req1", 32'(req1_ready), 32'(1));
    step();
    req1_valid = 0;
    step();
    #1 chk("t3_sum1", 32'(rsp_sum), 32'(16'h0002));
    chk("t3_cout1", 32'(rsp_cout), 32'(0));
    rsp1_ready = 1;
    step();

    // continuous valid on both, zero-wait responses: grants alternate
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) gq.push_back(0);
      else if (req1_ready) gq.push_back(1);
      step();
      if (m_acc0) begin req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom); end
      if (m_acc1) begin req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom); end
    end
    chk("alt_count", 32'(gq.size()), 32'(4));
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("alt_order", 32'(gq[i]), 32'(i % 2));
    drain();

    // response backpressure with req1 waiting
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 0;
    step();
    req0_valid = 0; req1_valid = 1; req1_a = 16'h00FF; req1_b = 16'h0001; req1_cin = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_sum", 32'(rsp_sum), 32'(16'h2345));
      chk("bp_busy", 32'(busy), 32'(1));
      chk("bp_req1_held", 32'(req1_ready), 32'(0));
      step();
    end
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    #1 chk("bp_req1_next", 32'(req1_ready), 32'(1));
    step();
    req1_valid = 0;
    drain();

    // reset while in CALC
    req0_valid = 1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_cin = 1;
    step();
    req0_valid = 0;
    rst_n = 0;
    #1 chk("rst_async_busy", 32'(busy), 32'(0));
    chk("rst_async_sum", 32'(rsp_sum), 32'(0));
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'(0));
      step();
    end
    req0_valid = 1; req1_valid = 1;
    #1 chk("rst_rr_zero", 32'({req0_ready, req1_ready}), 32'(2'b10));
    step();
    drain();

    // randomized traffic against the model
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 99) < 50);
        req0_a = rnd_op(); req0_b = rnd_op(); req0_cin = 1'($urandom);
        hold0 = req0_valid;
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 99) < 50);
        req1_a = rnd_op(); req1_b = rnd_op(); req1_cin = 1'($urandom);
        hold1 = req1_valid;
      end
      rsp0_ready = ($urandom_range(0, 99) < 60);
      rsp1_ready = ($urandom_range(0, 99) < 60);
      step();
      if (m_acc0) hold0 = 0;
      if (m_acc1) hold1 = 0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
